sipo_arbiter: RTL and testbench

SIPO_ARBITER -- requirements
Module: sipo_arbiter

---
 rtl/sipo_arbiter.sv | 129 ++++++++++++
 tb/tb_sipo_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sipo_arbiter
// Description : Round-robin arbiter over serial requesters; assembles the
//               granted source's LSB-first bit stream into a parallel word.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  Req_i,
    input  logic [N_SRC-1:0]  Valid_i,
    input  logic [N_SRC-1:0]  In_Data,
    input  logic              Ready_i,
    output logic [N_SRC-1:0]  Gnt_o,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Src_o,
    output logic              Valid_o,
    output logic              Abort_o,
    output logic              Busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0]       c_last_bit = 4'(DATA_W - 1);
    localparam logic [N_SRC-1:0] c_one_hot  = N_SRC'(1);

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_win;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_sr;

    logic [1:0]        w_pick;
    logic [1:0]        w_cand;
    logic              w_found;
    logic [DATA_W-1:0] w_shift;

    // First requester at or after the pointer, wrapping modulo the source count.
    always_comb begin
        w_pick  = 2'd0;
        w_cand  = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && Req_i[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_shift = {In_Data[r_win], r_sr[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd0;
            r_win    <= 2'd0;
            r_cnt    <= 4'd0;
            r_sr     <= '0;
            Gnt_o    <= '0;
            Out_Data <= '0;
            Src_o    <= 2'd0;
            Valid_o  <= 1'b0;
            Abort_o  <= 1'b0;
            Busy_o   <= 1'b0;
        end else begin
            Abort_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_win   <= w_pick;
                        Gnt_o   <= c_one_hot << w_pick;
                        r_cnt   <= 4'd0;
                        r_state <= ST_SHIFT;
                        Busy_o  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A dropped request wins over a bit arriving on the same edge.
                    if (!Req_i[r_win]) begin
                        r_cnt   <= 4'd0;
                        Gnt_o   <= '0;
                        Abort_o <= 1'b1;
                        r_ptr   <= r_win + 2'd1;
                        r_state <= ST_IDLE;
                        Busy_o  <= 1'b0;
                    end else if (Valid_i[r_win]) begin
                        r_sr <= w_shift;
                        if (r_cnt == c_last_bit) begin
                            Out_Data <= w_shift;
                            Src_o    <= r_win;
                            Valid_o  <= 1'b1;
                            Gnt_o    <= '0;
                            r_cnt    <= 4'd0;
                            r_state  <= ST_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Ready_i) begin
                        Valid_o <= 1'b0;
                        r_ptr   <= r_win + 2'd1;
                        r_state <= ST_IDLE;
                        Busy_o  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    Gnt_o   <= '0;
                    Valid_o <= 1'b0;
                    Busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_arbiter
// Description : Directed scenarios plus random traffic against a
//               transaction-level reference model of sipo_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Req_i = '0;
    logic [3:0] Valid_i = '0;
    logic [3:0] In_Data = '0;
    logic       Ready_i = 1'b0;
    logic [3:0] Gnt_o;
    logic [7:0] Out_Data;
    logic [1:0] Src_o;
    logic       Valid_o;
    logic       Abort_o;
    logic       Busy_o;

    sipo_arbiter #(.N_SRC(4), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Req_i    (Req_i),
        .Valid_i  (Valid_i),
        .In_Data  (In_Data),
        .Ready_i  (Ready_i),
        .Gnt_o    (Gnt_o),
        .Out_Data (Out_Data),
        .Src_o    (Src_o),
        .Valid_o  (Valid_o),
        .Abort_o  (Abort_o),
        .Busy_o   (Busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner of the current transfer, collected bits, pending word.
    int         m_owner;
    bit         m_hold;
    int         m_ptr;
    bit         m_bits[$];
    logic [3:0] e_gnt;
    logic [7:0] e_data;
    logic [1:0] e_src;
    logic       e_valid;
    logic       e_abort;
    logic       e_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 1'b0;
        m_ptr   = 0;
        m_bits.delete();
        e_gnt   = '0;
        e_data  = '0;
        e_src   = '0;
        e_valid = 1'b0;
        e_abort = 1'b0;
        e_busy  = 1'b0;
    endtask

    task automatic model_step();
        e_abort = 1'b0;
        if (m_hold) begin
            if (Ready_i) begin
                e_valid = 1'b0;
                e_busy  = 1'b0;
                m_hold  = 1'b0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else if (m_owner >= 0) begin
            if (!Req_i[m_owner]) begin
                e_gnt   = '0;
                e_abort = 1'b1;
                e_busy  = 1'b0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_bits.delete();
            end else if (Valid_i[m_owner]) begin
                m_bits.push_back(In_Data[m_owner]);
                if (m_bits.size() == 8) begin
                    int w;
                    w = 0;
                    foreach (m_bits[i]) w += int'(m_bits[i]) << i;
                    e_data  = 8'(w);
                    e_src   = 2'(m_owner);
                    e_valid = 1'b1;
                    e_gnt   = '0;
                    m_hold  = 1'b1;
                    m_bits.delete();
                end
            end
        end else if (Req_i != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (Req_i[s]) begin
                    m_owner = s;
                    break;
                end
            end
            e_gnt  = 4'(1 << m_owner);
            e_busy = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_eq("gnt",   Gnt_o,    e_gnt);
        check_eq("data",  Out_Data, e_data);
        check_eq("src",   Src_o,    e_src);
        check_eq("valid", Valid_o,  e_valid);
        check_eq("abort", Abort_o,  e_abort);
        check_eq("busy",  Busy_o,   e_busy);
    endtask

    // Asserts reset between clock edges so its asynchronous effect is visible.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_gnt",   Gnt_o,    0);
        check_eq("rst_data",  Out_Data, 0);
        check_eq("rst_src",   Src_o,    0);
        check_eq("rst_valid", Valid_o,  0);
        check_eq("rst_abort", Abort_o,  0);
        check_eq("rst_busy",  Busy_o,   0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int src);
        for (int k = 0; k < 8 && !Gnt_o[src]; k++) step();
        check_eq("grant_wait", Gnt_o[src], 1);
    endtask

    // Sends nbits of w from src; other sources get random noise on Valid/In.
    task automatic send_bits(input int src, input logic [7:0] w, input int nbits, input bit gappy);
        for (int i = 0; i < nbits; i++) begin
            Valid_i = 4'($urandom);
            In_Data = 4'($urandom);
            Valid_i[src] = 1'b1;
            In_Data[src] = w[i];
            step();
            if (gappy && i < nbits - 1) begin
                Valid_i = 4'($urandom);
                In_Data = 4'($urandom);
                Valid_i[src] = 1'b0;
                step();
            end
        end
        Valid_i = '0;
    endtask

    initial begin
        logic [7:0] w;
        model_reset();
        do_reset();

        // Single source, fixed word with downstream always ready.
        Ready_i = 1'b1;
        Req_i   = 4'b0001;
        wait_grant(0);
        send_bits(0, 8'h4D, 8, 1'b0);
        check_eq("t1_data",  Out_Data, 8'h4D);
        check_eq("t1_src",   Src_o,    0);
        check_eq("t1_valid", Valid_o,  1);
        Req_i = '0;
        step();
        check_eq("t1_valid_drop", Valid_o, 0);

        // All sources requesting: rotation 0,1,2,3,0 from a fresh pointer.
        do_reset();
        Req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 8'($urandom);
            wait_grant(k % 4);
            send_bits(k % 4, w, 8, 1'b0);
            check_eq("rr_src",  Src_o,    k % 4);
            check_eq("rr_data", Out_Data, w);
            step();
        end
        Req_i = '0;
        step();

        // Source 2 with valid toggling, then a stalled downstream for 5 cycles.
        Ready_i = 1'b0;
        Req_i   = 4'b0100;
        w = 8'hB6;
        wait_grant(2);
        send_bits(2, w, 8, 1'b1);
        check_eq("gap_data", Out_Data, w);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("hold_valid", Valid_o,  1);
            check_eq("hold_data",  Out_Data, w);
        end
        Ready_i = 1'b1;
        Req_i   = '0;
        step();
        check_eq("hold_exit_valid", Valid_o, 0);
        check_eq("hold_exit_busy",  Busy_o,  0);

        // Source 1 drops its request after 3 bits; source 2 is waiting.
        Req_i = 4'b0010;
        wait_grant(1);
        send_bits(1, 8'hFF, 3, 1'b0);
        Req_i = 4'b0100;
        step();
        check_eq("abort_pulse", Abort_o, 1);
        check_eq("abort_valid", Valid_o, 0);
        step();
        check_eq("abort_one_cycle", Abort_o, 0);
        check_eq("abort_next_gnt",  Gnt_o,   4'b0100);
        Req_i = '0;
        step();

        // Reset in the middle of a transfer, then pointer restarts at 0.
        Req_i = 4'b0001;
        wait_grant(0);
        send_bits(0, 8'h5A, 5, 1'b0);
        do_reset();
        Req_i = 4'b1010;
        step();
        check_eq("post_rst_gnt", Gnt_o, 4'b0010);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) Req_i[b] = ~Req_i[b];
            Valid_i = 4'($urandom);
            In_Data = 4'($urandom);
            Ready_i = ($urandom_range(0, 2) != 0);
            step();
            if (c % 500 == 499) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
